// File: rtl/rstatus_write_arbiter_pkg.sv
// Shared definitions for the regfile write-port arbiter: exception codes,
// the default status register index and the FSM state encoding.
package rstatus_write_arbiter_pkg;

  localparam logic [31:0] EXC_ADD_OVF  = 32'd1;
  localparam logic [31:0] EXC_ADDI_OVF = 32'd2;
  localparam logic [31:0] EXC_SUB_OVF  = 32'd3;
  localparam logic [31:0] EXC_MUL      = 32'd4;
  localparam logic [31:0] EXC_DIV      = 32'd5;

  localparam int RSTATUS_REG_DEFAULT = 30;

  typedef enum logic [0:0] {
    NORMAL      = 1'b0,
    FORCE_DRAIN = 1'b1
  } state_t;

endpackage

// File: rtl/rstatus_write_arbiter_exc_fifo.sv
// Small 32-bit synchronous FIFO holding deferred multdiv exception codes.
// A pop and a push in the same cycle are both honoured, even when full.
module exc_fifo #(
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [31:0]   pushData,
  input  logic          pop,
  output logic [31:0]   head,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rdPtr;
  logic [AW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign head   = mem[rdPtr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      if (doPush) wrPtr <= wrPtr + 1'b1;
      count <= count + CW'(doPush) - CW'(doPop);
    end
  end

  // Storage needs no reset: nothing is read before it has been written.
  always_ff @(posedge clock) begin
    if (doPush) mem[wrPtr] <= pushData;
  end

endmodule

// File: rtl/rstatus_write_arbiter.sv
// Regfile write-port arbiter sharing writeback, ALU and multdiv exception writes.
// Optional RSTATUS_SHADOW_EN adds last_exc_code and exc_count shadow outputs.
module rstatus_write_arbiter
  import rstatus_write_arbiter_pkg::*;
#(
  parameter int QUEUE_DEPTH = 2,
  parameter int MAX_WAIT    = 4,
  parameter int RSTATUS_REG = RSTATUS_REG_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_we,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  input  logic        alu_exc_valid,
  input  logic [31:0] alu_exc_code,
  input  logic        md_exc_valid,
  input  logic [31:0] md_exc_code,
  output logic        md_exc_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_data,
  output logic        stall,
  output logic        exc_pending,
`ifdef RSTATUS_SHADOW_EN
  output logic [31:0] last_exc_code,
  output logic [7:0]  exc_count,
`endif
  output state_t      dbgState
);

  localparam int CW   = $clog2(QUEUE_DEPTH) + 1;
  localparam int AGEW = $clog2(MAX_WAIT + 1);
  localparam logic [4:0]      RS_IDX  = 5'(RSTATUS_REG);
  localparam logic [AGEW-1:0] AGE_MAX = AGEW'(MAX_WAIT);

  state_t          state;
  logic [AGEW-1:0] age;
  logic [AGEW-1:0] ageNext;
  logic            fifoPush;
  logic            fifoPop;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [31:0]     fifoHead;
  logic [CW-1:0]   fifoCount;
  logic [CW-1:0]   countNext;
  logic            bypass;
  logic            excWrite;
  logic            refused;

  exc_fifo #(.DEPTH(QUEUE_DEPTH), .CW(CW)) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (fifoPush),
    .pushData (md_exc_code),
    .pop      (fifoPop),
    .head     (fifoHead),
    .full     (fifoFull),
    .empty    (fifoEmpty),
    .count    (fifoCount)
  );

  // md handshake: valid is held by multdiv while ready is low; a request is
  // accepted on valid && ready and is either bypassed to the port or pushed.
  always_comb begin
    rf_we    = 1'b0;
    rf_rd    = '0;
    rf_data  = '0;
    fifoPop  = 1'b0;
    bypass   = 1'b0;
    excWrite = 1'b0;
    if (!reset) begin
      if (state == NORMAL) begin
        if (alu_exc_valid) begin
          rf_we    = 1'b1;
          rf_rd    = RS_IDX;
          rf_data  = alu_exc_code;
          excWrite = 1'b1;
        end else if (wb_we && (wb_rd != 5'd0)) begin
          rf_we   = 1'b1;
          rf_rd   = wb_rd;
          rf_data = wb_data;
        end else if (!fifoEmpty) begin
          fifoPop  = 1'b1;
          rf_we    = 1'b1;
          rf_rd    = RS_IDX;
          rf_data  = fifoHead;
          excWrite = 1'b1;
        end else if (md_exc_valid) begin
          bypass   = 1'b1;
          rf_we    = 1'b1;
          rf_rd    = RS_IDX;
          rf_data  = md_exc_code;
          excWrite = 1'b1;
        end
      end else if (!fifoEmpty) begin
        fifoPop  = 1'b1;
        rf_we    = 1'b1;
        rf_rd    = RS_IDX;
        rf_data  = fifoHead;
        excWrite = 1'b1;
      end
    end
    md_exc_ready = !reset && (bypass || !fifoFull || fifoPop);
    fifoPush     = md_exc_valid && md_exc_ready && !bypass;
    refused      = md_exc_valid && !md_exc_ready;
    countNext    = fifoCount + CW'(fifoPush) - CW'(fifoPop);
    if (fifoEmpty || fifoPop) ageNext = '0;
    else if (age == AGE_MAX)  ageNext = age;
    else                      ageNext = age + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= NORMAL;
      stall <= 1'b0;
      age   <= '0;
    end else begin
      age <= ageNext;
      case (state)
        NORMAL: begin
          if ((ageNext == AGE_MAX) || (fifoFull && refused)) begin
            state <= FORCE_DRAIN;
            stall <= 1'b1;
          end
        end
        FORCE_DRAIN: begin
          if (countNext == '0) begin
            state <= NORMAL;
            stall <= 1'b0;
          end
        end
        default: begin
          state <= NORMAL;
          stall <= 1'b0;
        end
      endcase
    end
  end

  assign exc_pending = !fifoEmpty;
  assign dbgState    = state;

`ifdef RSTATUS_SHADOW_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      last_exc_code <= '0;
      exc_count     <= '0;
    end else if (excWrite) begin
      last_exc_code <= rf_data;
      if (exc_count != 8'hFF) exc_count <= exc_count + 1'b1;
    end
  end
`else
  logic unusedExcWrite;
  assign unusedExcWrite = excWrite;
`endif

endmodule

// File: doc/rstatus_write_arbiter.md
Name: rstatus_write_arbiter

Overview:
Owns the register-file write port at writeback and shares it between three requesters:
- normal instruction writeback;
- ALU exception writes (add/addi/sub overflow), which go to the status register;
- multdiv exception writes (mul/div), which arrive later from the multicycle unit.

Multdiv codes that cannot be written immediately are queued in a small FIFO. If a queued code waits too long, the block stalls the pipeline so the code is drained. It sits between the writeback stage and the regfile write port.

Parameters:
QUEUE_DEPTH, 2, multdiv exception FIFO entries (power of 2, ≥2)
MAX_WAIT, 4, cycles a non-empty queue may go without a pop before a forced drain
RSTATUS_REG, 30, destination register index for all exception codes

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
wb_we  in  1  writeback stage wants to write
wb_rd  in  5  writeback destination register
wb_data  in  32  writeback data
alu_exc_valid  in  1  writeback-stage ALU overflow; replaces the wb write
alu_exc_code  in  32  code 1/2/3 (add/addi/sub)
md_exc_valid  in  1  multdiv exception request
md_exc_code  in  32  code 4/5 (mul/div)
md_exc_ready  out  1  multdiv request accepted this cycle
rf_we  out  1  regfile write enable
rf_rd  out  5  regfile write address
rf_data  out  32  regfile write data
stall  out  1  freeze pipeline (writeback re-presented next cycle)
exc_pending  out  1  queue non-empty

Behaviour:
Reset and clocking
- One clock domain: clock. Reset is asynchronous and active-high.
- Reset values: FIFO empty, age=0, state=NORMAL, stall=0, rf_we=0, rf_rd=0, rf_data=0, exc_pending=0.
- Reset asserted mid-operation discards all queued codes.
- rf_* are combinational from the current inputs and state. Zero latency to the write port.

States
- NORMAL (stall=0). Highest priority first:
  1. alu_exc_valid → write RSTATUS_REG with alu_exc_code. wb_* is ignored.
  2. else if wb_we && wb_rd≠0 → write wb_rd with wb_data.
  3. else if the queue is non-empty → pop the head and write it to RSTATUS_REG.
  4. else if md_exc_valid → bypass: write md_exc_code directly; no push.
- FORCE_DRAIN (stall=1):
  - wb_we and alu_exc_valid are ignored; upstream holds them.
  - Pop one code per cycle and write it.
- wb_we with wb_rd=0 is not a write. The port is then free for step 3 or 4.

md handshake
- md_exc_ready = 1 when the code is bypassed, or when the queue is not full, or when a pop occurs this cycle.
- A request is accepted when md_exc_valid && md_exc_ready.
- An accepted request that is not bypassed is pushed.
- When md_exc_ready=0, the multdiv unit holds valid and code stable.
- Simultaneous push and pop when full keeps the count unchanged, with FIFO order preserved.

Age counter
- Counts cycles where the queue is non-empty and no pop occurs.
- Clears on any pop or when the queue is empty.
- Saturates at MAX_WAIT.

Transitions
- NORMAL→FORCE_DRAIN at the next edge when either:
  - age reaches MAX_WAIT, or
  - the queue is full and an md request is refused.
- FORCE_DRAIN→NORMAL at the edge where the post-update count is 0.

Widths and flags
- Codes pass through unmodified as 32 bits.
- Count width is $clog2(QUEUE_DEPTH)+1.
- exc_pending = (count≠0), registered view of the current count.

Optional Feature:
Macro: RSTATUS_SHADOW_EN
- Defined:
  - Adds output last_exc_code[31:0]: the last code written to RSTATUS_REG by any source. Resets to 0.
  - Adds output exc_count[7:0]: number of exception writes, saturating at 255.
- Undefined: neither output exists, and no extra flops are generated.

Decomposition:
Shared package:
- Exception code constants: EXC_ADD_OVF=1, EXC_ADDI_OVF=2, EXC_SUB_OVF=3, EXC_MUL=4, EXC_DIV=5.
- RSTATUS_REG default (30).
- State encoding: NORMAL, FORCE_DRAIN.

Sub-module:
- One natural sub-module: exc_fifo. Parameterised depth, 32-bit synchronous FIFO with push/pop/full/empty/count and async active-high reset.
- Arbitration, age counter and FSM stay in the top level.

Test Plan:
1. Reset mid-queue: push 4 then 5, assert reset → rf_we=0, exc_pending=0, stall=0; after release an idle cycle writes nothing.
2. Collision: alu_exc_valid=1 (code 1), wb_we=1 rd=7, md_exc_valid=1 (code 4) in the same cycle → r30←1; md accepted and queued; next idle cycle (wb_we=0) r30←4.
3. Bypass: idle pipeline, empty queue, md code 5 → same cycle rf_we=1, rf_rd=30, rf_data=5; exc_pending stays 0.
4. Starvation: queue holds 4; wb_we=1 rd=3 every cycle → after 4 cycles stall=1; next cycle r30←4; stall drops the following edge; wb write of rd=3 then completes.
5. Full backpressure: QUEUE_DEPTH=2, continuous wb writes, three md requests → third sees md_exc_ready=0 and the block enters FORCE_DRAIN; drained order is 4,5 then the held code; none lost.
6. rd=0 handling: wb_we=1 rd=0 with queued code 4 → r30←4 in the same cycle; r0 never written.
